// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the bridge FSM state type.
package ahb_pkg;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // HSIZE encodings
   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   // HBURST encoding: this bridge only issues single transfers
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   // HPROT: privileged data access, non-bufferable, non-cacheable
   localparam logic [3:0] HPROT_PRIV_DATA = 4'b0011;

   // Bridge FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_ERR  = 2'b11
   } bridge_state_e;

endpackage

// File: rtl/ahb_master_bridge.sv
// Single-outstanding, non-pipelined request-to-AHB master bridge.
// One transfer at a time: accept -> address phase -> data phase -> response.
// Optional wait-state timeout compiled in with macro AHB_MASTER_TIMEOUT_EN.
module ahb_master_bridge
   import ahb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  i_clk_ahb,
   input  logic                  i_rst_ahb,
   // request side
   input  logic                  i_valid,
   input  logic                  i_rd0_wr1,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [2:0]            i_size,
   output logic                  o_ready,
   // response side
   output logic                  o_rsp_valid,
   output logic                  o_rsp_err,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   // AHB master
   output logic [1:0]            o_htrans,
   output logic [2:0]            o_hsize,
   output logic                  o_hwrite,
   output logic [ADDR_WIDTH-1:0] o_haddr,
   output logic [DATA_WIDTH-1:0] o_hwdata,
   output logic [2:0]            o_hburst,
   output logic [3:0]            o_hprot,
   output logic                  o_hmastlock,
   input  logic                  i_hready,
   input  logic                  i_hresp,
   input  logic [DATA_WIDTH-1:0] i_hrdata
);

   bridge_state_e         state_q, state_d;
   logic [1:0]            htrans_q, htrans_d;
   logic [2:0]            hsize_q, hsize_d;
   logic                  hwrite_q, hwrite_d;
   logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  accept;
   logic                  timeout_hit;

`ifdef AHB_MASTER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Count consecutive stalled cycles while a transfer is in flight
   always_comb begin
      to_cnt_d    = '0;
      timeout_hit = 1'b0;
      if ((state_q != ST_IDLE) && !i_hready) begin
         if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   // Timeout counter register
   always_ff @(posedge i_clk_ahb) begin
      if (i_rst_ahb) to_cnt_q <= '0;
      else           to_cnt_q <= to_cnt_d;
   end
`else
   // Without the timeout the bridge waits on i_hready forever
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_hit        = 1'b0;
`endif

   // Ready is gated by reset so the requester never sees it during reset
   assign o_ready = (state_q == ST_IDLE) && !i_rst_ahb;
   assign accept  = (state_q == ST_IDLE) && i_valid;

   // Fixed AHB attributes
   assign o_hburst    = HBURST_SINGLE;
   assign o_hprot     = HPROT_PRIV_DATA;
   assign o_hmastlock = 1'b0;

   assign o_htrans    = htrans_q;
   assign o_hsize     = hsize_q;
   assign o_hwrite    = hwrite_q;
   assign o_haddr     = haddr_q;
   assign o_hwdata    = hwdata_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_rd_data   = rd_data_q;

   // State and output registers
   always_ff @(posedge i_clk_ahb) begin
      if (i_rst_ahb) begin
         state_q     <= ST_IDLE;
         htrans_q    <= HTRANS_IDLE;
         hsize_q     <= '0;
         hwrite_q    <= 1'b0;
         haddr_q     <= '0;
         hwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         htrans_q    <= htrans_d;
         hsize_q     <= hsize_d;
         hwrite_q    <= hwrite_d;
         haddr_q     <= haddr_d;
         hwdata_q    <= hwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Next-state logic; a timeout overrides any pending phase
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (i_valid) state_d = ST_ADDR;
         ST_ADDR: if (i_hready) state_d = ST_DATA;
         ST_DATA: begin
            if (i_hready)     state_d = ST_IDLE;
            else if (i_hresp) state_d = ST_ERR;
         end
         ST_ERR:  if (i_hready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (timeout_hit) state_d = ST_IDLE;
   end

   // Output logic: request capture, NONSEQ only for the address phase, response pulse
   always_comb begin
      haddr_d  = haddr_q;
      hsize_d  = hsize_q;
      hwrite_d = hwrite_q;
      hwdata_d = hwdata_q;
      if (accept) begin
         haddr_d  = i_addr;
         hsize_d  = i_size;
         hwrite_d = i_rd0_wr1;
         if (i_rd0_wr1) hwdata_d = i_wr_data;
      end

      htrans_d = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;

      rsp_valid_d = (((state_q == ST_DATA) || (state_q == ST_ERR)) && i_hready)
                    || timeout_hit;
      rsp_err_d   = rsp_valid_d &&
                    (timeout_hit || (state_q == ST_ERR) || i_hresp);

      rd_data_d = rd_data_q;
      if ((state_q == ST_DATA) && i_hready && !i_hresp && !hwrite_q) begin
         rd_data_d = i_hrdata;
      end
   end

endmodule

// File: tb/tb_ahb_master_bridge.sv
// Directed, table-driven bench for ahb_master_bridge (plus stall/timeout and reset sequences).
module tb_ahb_master_bridge;
   import ahb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid, wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [2:0]    size;
   logic          ready, rsp_valid, rsp_err;
   logic [DW-1:0] rd_data;
   logic [1:0]    htrans;
   logic [2:0]    hsize, hburst;
   logic          hwrite, hmastlock;
   logic [AW-1:0] haddr;
   logic [DW-1:0] hwdata, hrdata;
   logic [3:0]    hprot;
   logic          hready, hresp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ahb_master_bridge #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
   ) dut (
      .i_clk_ahb(clk), .i_rst_ahb(rst),
      .i_valid(valid), .i_rd0_wr1(wr), .i_addr(addr), .i_wr_data(wdata), .i_size(size),
      .o_ready(ready), .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rd_data(rd_data),
      .o_htrans(htrans), .o_hsize(hsize), .o_hwrite(hwrite), .o_haddr(haddr), .o_hwdata(hwdata),
      .o_hburst(hburst), .o_hprot(hprot), .o_hmastlock(hmastlock),
      .i_hready(hready), .i_hresp(hresp), .i_hrdata(hrdata)
   );

   typedef struct {
      logic        rst, valid, wr;
      logic [31:0] addr, wdata;
      logic [2:0]  size;
      logic        hready, hresp;
      logic [31:0] hrdata;
      logic        e_ready;
      logic [1:0]  e_htrans;
      logic        e_rv, e_re;
      logic [31:0] e_rd;
      logic        chk_a;
      logic [31:0] e_haddr;
      logic        e_hwrite;
      logic [2:0]  e_hsize;
      logic        chk_w;
      logic [31:0] e_hwdata;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(
      input logic r, v, w, input logic [31:0] a, d, input logic [2:0] s,
      input logic hr, hrs, input logic [31:0] hrd,
      input logic er, input logic [1:0] eht, input logic erv, ere, input logic [31:0] erd,
      input logic ca, input logic [31:0] eha, input logic ehw, input logic [2:0] ehs,
      input logic cw, input logic [31:0] ehwd);
      vec_t t;
      t.rst = r; t.valid = v; t.wr = w; t.addr = a; t.wdata = d; t.size = s;
      t.hready = hr; t.hresp = hrs; t.hrdata = hrd;
      t.e_ready = er; t.e_htrans = eht; t.e_rv = erv; t.e_re = ere; t.e_rd = erd;
      t.chk_a = ca; t.e_haddr = eha; t.e_hwrite = ehw; t.e_hsize = ehs;
      t.chk_w = cw; t.e_hwdata = ehwd;
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst = t.rst; valid = t.valid; wr = t.wr; addr = t.addr; wdata = t.wdata; size = t.size;
      hready = t.hready; hresp = t.hresp; hrdata = t.hrdata;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   localparam logic [1:0] I = HTRANS_IDLE;
   localparam logic [1:0] N = HTRANS_NONSEQ;

   initial begin
      rst = 1'b1; valid = 1'b0; wr = 1'b0; addr = '0; wdata = '0; size = '0;
      hready = 1'b1; hresp = 1'b0; hrdata = '0;

      //   rst v w addr          wdata         size        hr hrs hrdata       | rdy htr rv re rd_data      ca haddr         hw hsize       cw hwdata
      // reset, then first idle cycle
      add(1, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h0,         0, I, 0,0, 32'h0,        1, 32'h0,        0, 3'd0,       1, 32'h0);
      add(1, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h0,         0, I, 0,0, 32'h0,        1, 32'h0,        0, 3'd0,       1, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h0,         1, I, 0,0, 32'h0,        1, 32'h0,        0, 3'd0,       1, 32'h0);
      // write 0x1000 = DEADBEEF, zero wait states
      add(0, 1,1, 32'h1000,     32'hDEADBEEF, HSIZE_WORD, 1, 0, 32'hA5A5A5A5,  1, I, 0,0, 32'h0,        1, 32'h0,        0, 3'd0,       0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'hA5A5A5A5,  0, N, 0,0, 32'h0,        1, 32'h1000,     1, HSIZE_WORD, 1, 32'hDEADBEEF);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'hA5A5A5A5,  0, I, 0,0, 32'h0,        0, 32'h0,        0, 3'd0,       1, 32'hDEADBEEF);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'hA5A5A5A5,  1, I, 1,0, 32'h0,        0, 32'h0,        0, 3'd0,       0, 32'h0);
      // read 0x2004, three data-phase wait states
      add(0, 1,0, 32'h2004,     32'h0,        HSIZE_WORD, 1, 0, 32'hAAAA0000,  1, I, 0,0, 32'h0,        0, 32'h0,        0, 3'd0,       0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'hAAAA0001,  0, N, 0,0, 32'h0,        1, 32'h2004,     0, HSIZE_WORD, 0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       0, 0, 32'h11111111,  0, I, 0,0, 32'h0,        1, 32'h2004,     0, HSIZE_WORD, 0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       0, 0, 32'h22222222,  0, I, 0,0, 32'h0,        1, 32'h2004,     0, HSIZE_WORD, 0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       0, 0, 32'h33333333,  0, I, 0,0, 32'h0,        1, 32'h2004,     0, HSIZE_WORD, 0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h12345678,  0, I, 0,0, 32'h0,        1, 32'h2004,     0, HSIZE_WORD, 0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h99999999,  1, I, 1,0, 32'h12345678, 0, 32'h0,        0, 3'd0,       0, 32'h0);
      // write 0x3000 answered with a two-cycle ERROR
      add(0, 1,1, 32'h3000,     32'h0BADF00D, HSIZE_HALF, 1, 0, 32'h0,         1, I, 0,0, 32'h12345678, 0, 32'h0,        0, 3'd0,       0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h0,         0, N, 0,0, 32'h12345678, 1, 32'h3000,     1, HSIZE_HALF, 1, 32'h0BADF00D);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       0, 1, 32'h77777777,  0, I, 0,0, 32'h12345678, 0, 32'h0,        0, 3'd0,       1, 32'h0BADF00D);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 1, 32'h77777777,  0, I, 0,0, 32'h12345678, 0, 32'h0,        0, 3'd0,       1, 32'h0BADF00D);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h77777777,  1, I, 1,1, 32'h12345678, 0, 32'h0,        0, 3'd0,       0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h0,         1, I, 0,0, 32'h12345678, 0, 32'h0,        0, 3'd0,       0, 32'h0);
      // read 0x4008 aborted by reset in the data phase
      add(0, 1,0, 32'h4008,     32'h0,        HSIZE_WORD, 1, 0, 32'h0,         1, I, 0,0, 32'h12345678, 0, 32'h0,        0, 3'd0,       0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h0,         0, N, 0,0, 32'h12345678, 1, 32'h4008,     0, HSIZE_WORD, 0, 32'h0);
      add(1, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h55AA55AA,  0, I, 0,0, 32'h12345678, 0, 32'h0,        0, 3'd0,       0, 32'h0);
      add(1, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h55AA55AA,  0, I, 0,0, 32'h0,        1, 32'h0,        0, 3'd0,       1, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h55AA55AA,  1, I, 0,0, 32'h0,        1, 32'h0,        0, 3'd0,       1, 32'h0);
      // back-to-back with valid held high; one address-phase wait on the first
      add(0, 1,1, 32'h5000,     32'h11112222, HSIZE_BYTE, 1, 0, 32'h0,         1, I, 0,0, 32'h0,        0, 32'h0,        0, 3'd0,       0, 32'h0);
      add(0, 1,0, 32'h6000,     32'h0,        HSIZE_WORD, 0, 0, 32'h0,         0, N, 0,0, 32'h0,        1, 32'h5000,     1, HSIZE_BYTE, 1, 32'h11112222);
      add(0, 1,0, 32'h6000,     32'h0,        HSIZE_WORD, 1, 0, 32'h0,         0, N, 0,0, 32'h0,        1, 32'h5000,     1, HSIZE_BYTE, 1, 32'h11112222);
      add(0, 1,0, 32'h6000,     32'h0,        HSIZE_WORD, 1, 0, 32'h0,         0, I, 0,0, 32'h0,        1, 32'h5000,     1, HSIZE_BYTE, 1, 32'h11112222);
      add(0, 1,0, 32'h6000,     32'h0,        HSIZE_WORD, 1, 0, 32'h0,         1, I, 1,0, 32'h0,        0, 32'h0,        0, 3'd0,       0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h0,         0, N, 0,0, 32'h0,        1, 32'h6000,     0, HSIZE_WORD, 0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'hCAFEF00D,  0, I, 0,0, 32'h0,        0, 32'h0,        0, 3'd0,       0, 32'h0);
      add(0, 0,0, 32'h0,        32'h0,        3'd0,       1, 0, 32'h0,         1, I, 1,0, 32'hCAFEF00D, 0, 32'h0,        0, 3'd0,       0, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         next_cycle();
         drive(vecs[i]);
         @(negedge clk);
         $display("step %0d rst=%0b valid=%0b hready=%0b -> ready=%0b htrans=%0d rsp=%0b err=%0b rd=%h",
                  i, rst, valid, hready, ready, htrans, rsp_valid, rsp_err, rd_data);
         check("ready",     i, 32'(ready),     32'(vecs[i].e_ready));
         check("htrans",    i, 32'(htrans),    32'(vecs[i].e_htrans));
         check("rsp_valid", i, 32'(rsp_valid), 32'(vecs[i].e_rv));
         check("rsp_err",   i, 32'(rsp_err),   32'(vecs[i].e_re));
         check("rd_data",   i, rd_data,        vecs[i].e_rd);
         if (vecs[i].chk_a) begin
            check("haddr",  i, haddr,          vecs[i].e_haddr);
            check("hwrite", i, 32'(hwrite),    32'(vecs[i].e_hwrite));
            check("hsize",  i, 32'(hsize),     32'(vecs[i].e_hsize));
         end
         if (vecs[i].chk_w) begin
            check("hwdata", i, hwdata,         vecs[i].e_hwdata);
         end
         check("hburst",    i, 32'(hburst),    32'(HBURST_SINGLE));
         check("hprot",     i, 32'(hprot),     32'h3);
         check("hmastlock", i, 32'(hmastlock), 32'h0);
      end

      // Stalled slave: hready low from the address phase onward
      next_cycle();
      rst = 1'b0; valid = 1'b1; wr = 1'b0; addr = 32'h7000; size = HSIZE_WORD; hready = 1'b1; hresp = 1'b0;
      @(negedge clk);
      $display("stall accept ready=%0b", ready);
      check("stall_accept", 100, 32'(ready), 32'h1);
      for (int k = 0; k < 20; k++) begin
         logic       exp_rv;
         logic [1:0] exp_ht;
         next_cycle();
         valid  = 1'b0;
         hready = 1'b0;
         @(negedge clk);
`ifdef AHB_MASTER_TIMEOUT_EN
         exp_rv = (k == 8);
         exp_ht = (k < 8) ? N : I;
`else
         exp_rv = 1'b0;
         exp_ht = N;
`endif
         $display("stall cycle %0d htrans=%0d rsp=%0b err=%0b", k, htrans, rsp_valid, rsp_err);
         check("stall_rsp_valid", 101 + k, 32'(rsp_valid), 32'(exp_rv));
         check("stall_rsp_err",   101 + k, 32'(rsp_err),   32'(exp_rv));
         check("stall_htrans",    101 + k, 32'(htrans),    32'(exp_ht));
      end

      // Recover with reset; ready returns the first cycle after release
      next_cycle();
      rst = 1'b1; hready = 1'b1;
      next_cycle();
      @(negedge clk);
      $display("reset hold ready=%0b htrans=%0d", ready, htrans);
      check("rst_ready",  200, 32'(ready),  32'h0);
      check("rst_htrans", 200, 32'(htrans), 32'(I));
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      $display("reset release ready=%0b rsp=%0b", ready, rsp_valid);
      check("rel_ready", 201, 32'(ready),     32'h1);
      check("rel_rsp",   201, 32'(rsp_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_master_bridge.md
AHB_MASTER_BRIDGE -- requirements
Module: ahb_master_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AHB and request data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AHB and request address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: wait-state limit, used only when the timeout feature is compiled in.
REQ-004 SHALL have one clock and a synchronous active-high reset: i_clk_ahb  in  1  AHB clock; i_rst_ahb  in  1  reset, sampled on the i_clk_ahb rising edge.
REQ-005 SHALL have request ports: i_valid  in  1  request valid; i_rd0_wr1  in  1  0=read 1=write; i_addr  in  ADDR_WIDTH  byte address; i_wr_data  in  DATA_WIDTH  write data; i_size  in  3  HSIZE code; o_ready  out  1  request accepted when high with i_valid.
REQ-006 SHALL have response ports: o_rsp_valid  out  1  one-cycle completion pulse; o_rsp_err  out  1  error flag, valid with o_rsp_valid; o_rd_data  out  DATA_WIDTH  read data, valid with o_rsp_valid.
REQ-007 SHALL have AHB master ports: o_htrans  out  2; o_hsize  out  3; o_hwrite  out  1; o_haddr  out  ADDR_WIDTH; o_hwdata  out  DATA_WIDTH; o_hburst  out  3; o_hprot  out  4; o_hmastlock  out  1; i_hready  in  1; i_hresp  in  1; i_hrdata  in  DATA_WIDTH.

Function
REQ-008 SHALL be single-outstanding and non-pipelined: SINGLE bursts only; o_hburst=3'b000, o_hprot=4'b0011, o_hmastlock=0 at all times.
REQ-009 SHALL implement FSM IDLE, ADDR, DATA, ERR; o_ready=1 only in IDLE.
REQ-010 IDLE: on i_valid&&o_ready, SHALL register addr/size/dir/wdata and enter ADDR the next cycle.
REQ-011 ADDR: SHALL drive o_htrans=NONSEQ(2'b10) with registered o_haddr/o_hsize/o_hwrite; SHALL hold them stable while i_hready=0; on i_hready=1, SHALL enter DATA.
REQ-012 DATA: SHALL drive o_htrans=IDLE(2'b00) and, for writes, o_hwdata = registered data; o_hwdata SHALL hold while i_hready=0.
REQ-013 DATA with i_hready=1, i_hresp=0: SHALL pulse o_rsp_valid=1, o_rsp_err=0, capture i_hrdata into o_rd_data for reads, and return to IDLE.
REQ-014 DATA with i_hready=0, i_hresp=1 (first ERROR cycle): SHALL enter ERR; ERR with i_hready=1 SHALL pulse o_rsp_valid=1, o_rsp_err=1 and return to IDLE.
REQ-015 o_rd_data SHALL hold its value until the next read completion; it is unchanged on writes and errors.
REQ-016 Latency: with zero wait states, accept at cycle N -> address phase N+1 -> data phase N+2 -> o_rsp_valid at N+3; each wait state adds one cycle.
REQ-017 o_htrans SHALL be IDLE in every state except ADDR; all AHB outputs SHALL be registered.
REQ-018 i_valid while not in IDLE SHALL be ignored (o_ready=0); the requester holds the request.

Reset
REQ-019 On i_rst_ahb=1, the FSM SHALL go to IDLE and outputs SHALL reset to: o_htrans=0, o_haddr=0, o_hwdata=0, o_hsize=0, o_hwrite=0, o_rsp_valid=0, o_rsp_err=0, o_rd_data=0, o_ready=0 during reset and 1 in the cycle after reset deasserts.
REQ-020 Reset mid-transfer SHALL abort the transfer with no o_rsp_valid pulse; o_htrans SHALL be IDLE from the first reset cycle.

Configuration
REQ-021 Macro AHB_MASTER_TIMEOUT_EN defined: a counter SHALL count consecutive i_hready=0 cycles in ADDR/DATA/ERR; on reaching TIMEOUT_CYCLES it SHALL force IDLE, pulse o_rsp_valid=1 with o_rsp_err=1, and drive o_htrans=IDLE.
REQ-022 Macro not defined: no counter SHALL be present and the bridge waits on i_hready indefinitely; TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-023 Shared package ahb_pkg SHALL hold the HTRANS, HSIZE and HBURST encodings and the FSM state enum.
REQ-024 No sub-module: FSM, request registers and optional timeout counter SHALL be in a single module.

Verification
REQ-025 Write 0x1000=0xDEADBEEF, i_size=3'b010, zero wait states -> NONSEQ at N+1, o_hwdata=0xDEADBEEF at N+2, o_rsp_valid=1 with o_rsp_err=0 at N+3.
REQ-026 Read 0x2004, slave inserts 3 wait states returning 0x12345678 -> address held stable, o_rsp_valid at N+6, o_rd_data=0x12345678.
REQ-027 Write to a slave returning a 2-cycle ERROR -> o_htrans=IDLE throughout, one o_rsp_valid with o_rsp_err=1, o_rd_data unchanged.
REQ-028 Reset asserted during the DATA phase of a read -> no o_rsp_valid; o_htrans=0; o_ready=1 in the first cycle after reset deasserts.
REQ-029 With AHB_MASTER_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, i_hready held 0 -> error response 8 cycles after i_hready first goes low; without the macro, no response.
REQ-030 Back-to-back requests with i_valid held high -> second request accepted only in the IDLE cycle after the first o_rsp_valid; no overlapping NONSEQ.
